// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO, configurable framing and bit period
// Ports:
//   sysclk, Reset_n        - clock (rising edge) and asynchronous active-low reset
//   wr_en, wr_data         - push a word into the FIFO (dropped when full)
//   ovf_clr                - clears the sticky overflow flag
//   full, empty, count     - FIFO occupancy, excluding the word being shifted out
//   overflow               - sticky, a push was dropped
//   busy, tx_done          - frame in progress / one-cycle end-of-frame pulse
//   UART_OUT               - registered serial line, idle high
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 512,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int IDLE_GAP     = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sysclk,
    input  logic                          Reset_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          ovf_clr,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          UART_OUT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP == 0 ? 0 : IDLE_GAP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] shifter;
    logic                 par_bit;
    logic [BW-1:0]        baud;
    logic [3:0]           bit_cnt;
    logic                 push, pop, bit_end, frame_end;

    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign push      = wr_en && !full;
    assign bit_end   = baud == BW'(CLKS_PER_BIT - 1);
    assign frame_end = bit_end && ((state == STOP && bit_cnt == STOP_LAST && IDLE_GAP == 0) ||
                                   (state == GAP && bit_cnt == GAP_LAST));
    // a frame end with data waiting reloads directly, so back-to-back frames have no idle cycle
    assign pop       = !empty && (state == IDLE || frame_end);

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            UART_OUT <= 1'b1;
            shifter  <= '0;
            par_bit  <= 1'b0;
            baud     <= '0;
            bit_cnt  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= (wr_en && full) || (overflow && !ovf_clr);
            tx_done  <= frame_end;
            // every state change happens on a bit boundary or from IDLE, so this restarts the bit timer on entry
            baud     <= (bit_end || state == IDLE) ? '0 : baud + 1'b1;
            if (pop) begin
                shifter  <= mem[rd_ptr];
                par_bit  <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
                state    <= START;
                UART_OUT <= 1'b0;
                busy     <= 1'b1;
            end else if (frame_end) begin
                state    <= IDLE;
                UART_OUT <= 1'b1;
                busy     <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        UART_OUT <= shifter[0];
                        shifter  <= shifter >> 1;
                    end
                    DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            state    <= (PARITY != 0) ? PAR : STOP;
                            UART_OUT <= (PARITY != 0) ? par_bit : 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            UART_OUT <= shifter[0];
                            shifter  <= shifter >> 1;
                        end
                    end
                    PAR: begin
                        state    <= STOP;
                        UART_OUT <= 1'b1;
                        bit_cnt  <= '0;
                    end
                    STOP: begin
                        state   <= (bit_cnt == STOP_LAST) ? GAP : STOP;
                        bit_cnt <= (bit_cnt == STOP_LAST) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    GAP:     bit_cnt <= bit_cnt + 4'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench over four parameter sets against a frame-level model
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n, wr_en, ovf_clr;
    logic [8:0] wr_data;
    logic [1:0] sel;
    logic       we [4];
    logic       oc [4];
    logic       ln [4];
    logic       bz [4];
    logic       td [4];
    logic       fl [4];
    logic       em [4];
    logic       ov [4];
    logic [2:0] ct [4];
    logic       line, busy, tx_done, full, empty, overflow;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;
    int CPB [4] = '{512, 4, 4, 4};
    int DB  [4] = '{8, 8, 7, 7};
    int PAR [4] = '{0, 0, 2, 1};
    int SB  [4] = '{1, 1, 2, 2};
    int GP  [4] = '{0, 0, 1, 1};

    always #3 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            we[i] = wr_en && sel == 2'(i);
            oc[i] = ovf_clr && sel == 2'(i);
        end
    end

    assign line     = ln[sel];
    assign busy     = bz[sel];
    assign tx_done  = td[sel];
    assign full     = fl[sel];
    assign empty    = em[sel];
    assign overflow = ov[sel];
    assign count    = ct[sel];

    uart_tx_fifo u0 (.sysclk(clk), .Reset_n(rst_n), .wr_en(we[0]), .wr_data(wr_data[7:0]), .ovf_clr(oc[0]),
        .full(fl[0]), .empty(em[0]), .count(ct[0]), .overflow(ov[0]), .busy(bz[0]), .tx_done(td[0]), .UART_OUT(ln[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4)) u1 (.sysclk(clk), .Reset_n(rst_n), .wr_en(we[1]), .wr_data(wr_data[7:0]),
        .ovf_clr(oc[1]), .full(fl[1]), .empty(em[1]), .count(ct[1]), .overflow(ov[1]), .busy(bz[1]),
        .tx_done(td[1]), .UART_OUT(ln[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .IDLE_GAP(1)) u2 (.sysclk(clk),
        .Reset_n(rst_n), .wr_en(we[2]), .wr_data(wr_data[6:0]), .ovf_clr(oc[2]), .full(fl[2]), .empty(em[2]),
        .count(ct[2]), .overflow(ov[2]), .busy(bz[2]), .tx_done(td[2]), .UART_OUT(ln[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .IDLE_GAP(1)) u3 (.sysclk(clk),
        .Reset_n(rst_n), .wr_en(we[3]), .wr_data(wr_data[6:0]), .ovf_clr(oc[3]), .full(fl[3]), .empty(em[3]),
        .count(ct[3]), .overflow(ov[3]), .busy(bz[3]), .tx_done(td[3]), .UART_OUT(ln[3]));

    function automatic int flen(input int s);
        return 1 + DB[s] + (PAR[s] != 0 ? 1 : 0) + SB[s] + GP[s];
    endfunction

    // expected line level for bit-time k of a frame carrying d
    function automatic logic ebit(input int s, input logic [8:0] d, input int k);
        int ones = $countones(d & 9'((1 << DB[s]) - 1));
        if (k == 0) return 1'b0;
        if (k <= DB[s]) return d[k-1];
        if (PAR[s] != 0 && k == DB[s] + 1) return PAR[s] == 1 ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic push(input logic [8:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // entered at the negedge t0 cycles after the frame's start edge; leaves at the negedge after frame end
    task automatic check_frame(input logic [8:0] d, input int t0);
        int L = flen(sel);
        int bad;
        for (int k = 0; k < L; k++) begin
            bad = 0;
            for (int c = 0; c < CPB[sel]; c++) begin
                int t = k * CPB[sel] + c;
                if (t < t0) continue;
                if (t > t0) @(negedge clk);
                if (line !== ebit(sel, d, k) || busy !== 1'b1 || (t > 0 && tx_done !== 1'b0)) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame_bit sel=%0d data=%h bit=%0d bad_cycles=%0d required 0 (line should be %b)",
                         sel, d, k, bad, ebit(sel, d, k));
            end
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1) begin
            errors++;
            $display("FAIL tx_done_end sel=%0d data=%h got %b required 1", sel, d, tx_done);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || line !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL %s busy=%b line=%b empty=%b required 0 1 1", name, busy, line, empty);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (ln[s] !== 1'b1 || bz[s] !== 1'b0 || td[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_line sel=%0d line/busy/tx_done=%b%b%b required 100", s, ln[s], bz[s], td[s]);
            end
            checks++;
            if (ov[s] !== 1'b0 || ct[s] !== 3'd0 || em[s] !== 1'b1 || fl[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_fifo sel=%0d ovf=%b count=%0d empty=%b full=%b required 0 0 1 0",
                         s, ov[s], ct[s], em[s], fl[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [8:0] w;
        sel = 2'd0;
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 9'h01 : 9'($urandom_range(0, 255));
            push(w);
            checks++;
            if (empty !== 1'b0 || count !== 3'd1) begin
                errors++;
                $display("FAIL push_latency empty=%b count=%0d required 0 1", empty, count);
            end
            @(negedge clk);
            check_frame(w, 0);
            check_idle("single_idle");
            @(negedge clk);
            checks++;
            if (tx_done !== 1'b0) begin
                errors++;
                $display("FAIL tx_done_pulse got %b required 0", tx_done);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] a, b;
        sel = 2'd1;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 9'h01 : 9'($urandom_range(0, 255));
            b = (i == 0) ? 9'hFF : 9'($urandom_range(0, 255));
            push(a);
            push(b);
            checks++;
            if (count !== 3'd1) begin
                errors++;
                $display("FAIL push_pop_count got %0d required 1", count);
            end
            check_frame(a, 0);
            check_frame(b, 0);
            check_idle("b2b_idle");
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        logic [8:0] w [6];
        sel = 2'd1;
        for (int i = 0; i < 6; i++) w[i] = 9'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) push(w[i]);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_fill full=%b count=%0d ovf=%b required 1 4 1", full, count, overflow);
        end
        check_frame(w[0], 4);
        for (int i = 1; i < 5; i++) check_frame(w[i], 0);
        check_idle("ovf_drain_idle");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %b required 1", overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b required 0", overflow);
        end
    endtask

    task automatic test_parity;
        logic [8:0] w;
        for (int s = 2; s < 4; s++) begin
            sel = 2'(s);
            for (int i = 0; i < 3; i++) begin
                w = (i == 0) ? 9'h55 : 9'($urandom_range(0, 127));
                push(w);
                @(negedge clk);
                check_frame(w, 0);
                check_idle("parity_idle");
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] w;
        int bad = 0;
        sel = 2'd1;
        push(9'h00);
        push(9'($urandom_range(0, 255)));
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (line !== 1'b1 || count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid line=%b count=%0d busy=%b required 1 0 0", line, count, busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || line !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold bad_cycles=%0d required 0", bad);
        end
        rst_n = 1'b1;
        @(negedge clk);
        w = 9'($urandom_range(0, 255));
        push(w);
        @(negedge clk);
        check_frame(w, 0);
        check_idle("reset_recover_idle");
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        ovf_clr = 1'b0;
        sel     = 2'd0;
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_parity;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, synthesizable UART transmitter with an input FIFO, used on-chip as the PLMIPS serial output path and in simulation as a reusable stimulus source driving `UART_IN` of a device under test, replacing hand-written per-bit delay sequences. It generalises fixed 8N1 framing to configurable data width, parity, stop bits, inter-frame gap and bit period. Software or a bench pushes words; the block serialises them back-to-back with exact bit timing.

## Interface
- `CLKS_PER_BIT`, 512, sysclk cycles per bit; ≥2. 512 gives 3072 ns/bit at a 6 ns clock.
- `DATA_BITS`, 8, payload bits per frame; 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits; 1 or 2.
- `IDLE_GAP`, 0, extra idle-high bit times after each frame; 0..15.
- `FIFO_DEPTH`, 4, FIFO entries; power of 2, ≥2.
- `sysclk` in 1: single clock; all logic on its rising edge.
- `Reset_n` in 1: reset is asynchronous and active-low.
- `wr_en` in 1: push request.
- `wr_data` in DATA_BITS: word to push.
- `ovf_clr` in 1: clears `overflow`.
- `full` out 1: FIFO holds FIFO_DEPTH words.
- `empty` out 1: FIFO holds 0 words.
- `count` out $clog2(FIFO_DEPTH)+1: words in FIFO (not counting word in shifter).
- `overflow` out 1: sticky; a push was dropped.
- `busy` out 1: frame in progress (START through GAP).
- `tx_done` out 1: one-cycle pulse at end of each frame.
- `UART_OUT` out 1: serial line, idle high.

## Operation
- Reset values: `UART_OUT`=1, `busy`=0, `tx_done`=0, `overflow`=0, `count`=0, `empty`=1, `full`=0, FSM=IDLE, pointers 0.
- Push: `wr_en` && !`full` stores `wr_data`. `wr_en` while `full` drops the word and sets `overflow`, even if a pop occurs the same cycle (full is registered state).
- `ovf_clr` clears `overflow`; simultaneous new overflow wins (stays 1).
- FSM states: IDLE, START, DATA, PAR, STOP, GAP.
- IDLE: `UART_OUT`=1; if !`empty`, pop head into shifter, go START.
- START: line 0 for one bit time -> DATA.
- DATA: DATA_BITS bits, LSB first -> PAR if PARITY≠0, else STOP.
- PAR: odd mode: XOR of data bits inverted; even: XOR of data bits.
- STOP: line 1 for STOP_BITS bit times -> GAP if IDLE_GAP≠0, else frame end.
- GAP: line 1 for IDLE_GAP bit times -> frame end.
- Frame end: pulse `tx_done`; if FIFO non-empty, pop and enter START on the same edge (no idle cycle); else IDLE.
- Push and pop in same cycle: `count` unchanged, both take effect.
- Baud counter runs 0..CLKS_PER_BIT-1, restarts at every state entry; bit counter tracks DATA/STOP/GAP positions.
- `UART_OUT` is registered (no glitches).

## Timing
- Push accepted at edge N into an empty FIFO with FSM in IDLE: `empty`=0 after N; pop at N+1; `UART_OUT` low and `busy` high after N+1. Latency 2 cycles.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length = (1+DATA_BITS+(PARITY≠0)+STOP_BITS+IDLE_GAP)×CLKS_PER_BIT cycles.
- `tx_done` high for the cycle after the last bit of the frame completes; `busy` falls on that same edge unless a back-to-back frame starts.
- `count`/`full`/`empty` update on the edge following the push/pop.
- Reset asserted mid-frame: line returns to 1 immediately (async), FIFO contents discarded, no `tx_done`.

## Test plan
- Reset: hold `Reset_n`=0 -> all outputs at reset values; `UART_OUT`=1 throughout.
- Default params, push 0x01 -> line: 0, 1, 0×7, 1, each 512 cycles; `tx_done` once, 5120 cycles after start edge.
- CLKS_PER_BIT=4, push 0x01 then 0xFF back-to-back -> second start bit immediately follows first stop bit; total 80 cycles; two `tx_done` pulses 40 cycles apart.
- FIFO_DEPTH=4, CLKS_PER_BIT=4: push 6 words in consecutive cycles -> first popped, 4 stored, sixth dropped; `full`=1, `overflow`=1 until `ovf_clr`.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, IDLE_GAP=1, push 0x55 -> parity bit 0, 12 bit-time frame; PARITY=1 -> parity bit 1.
- Assert `Reset_n`=0 in the middle of the DATA state -> `UART_OUT`=1 at once, `count`=0, no `tx_done`; after release, new push transmits correctly.
